// File: rtl/jkff_structural.sv
// jkff_structural: bank of WIDTH independent JK flip-flops built from a
// 2:1-mux tree feeding a plain D register. Synchronous active-high reset.
// Optional macro JKFF_HOLD_EN adds a per-bit enable (en) that forces hold.

// Leaf 2:1 multiplexer: y = sel ? b : a.
module jkff_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

module jkff_structural #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef JKFF_HOLD_EN
    input  logic [WIDTH-1:0] en,
`endif
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // State register powers up at the reset value so outputs are defined
    // even if rst is tied low.
    logic [WIDTH-1:0] state = RESET_VAL;
    logic [WIDTH-1:0] state_n;
    logic [WIDTH-1:0] path_j0;
    logic [WIDTH-1:0] path_j1;
    logic [WIDTH-1:0] d_jk;
    logic [WIDTH-1:0] d_next;

    assign state_n = ~state;

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        // j=0 path: k selects hold (q) or reset (0).
        jkff_mux2 u_lvl1_j0 (
            .a   (state[gi]),
            .b   (1'b0),
            .sel (k[gi]),
            .y   (path_j0[gi])
        );

        // j=1 path: k selects set (1) or toggle (~q).
        jkff_mux2 u_lvl1_j1 (
            .a   (1'b1),
            .b   (state_n[gi]),
            .sel (k[gi]),
            .y   (path_j1[gi])
        );

        // j picks between the two level-1 results.
        jkff_mux2 u_lvl2 (
            .a   (path_j0[gi]),
            .b   (path_j1[gi]),
            .sel (j[gi]),
            .y   (d_jk[gi])
        );

`ifdef JKFF_HOLD_EN
        // Enable stage: en=0 recirculates the current state.
        jkff_mux2 u_hold (
            .a   (state[gi]),
            .b   (d_jk[gi]),
            .sel (en[gi]),
            .y   (d_next[gi])
        );
`else
        assign d_next[gi] = d_jk[gi];
`endif
    end

    // D register with synchronous reset taking priority over the mux tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VAL;
        end else begin
            state <= d_next;
        end
    end

    assign q    = state;
    assign qbar = ~state;

endmodule

// File: tb/tb_jkff_structural.sv
// Self-checking bench for jkff_structural: directed table, corner sequences
// and randomized stimulus against a behavioural JK model.
module tb_jkff_structural;

    logic       clk;
    logic       rst;
    logic [0:0] j1, k1, q1, qbar1;
    logic [3:0] j4, k4, q4, qbar4;
`ifdef JKFF_HOLD_EN
    logic [0:0] en1;
    logic [3:0] en4;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic j;
        logic k;
        logic exp_q;
    } vec_t;

    vec_t vecs[$];

    jkff_structural #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
`ifdef JKFF_HOLD_EN
        .en   (en1),
`endif
        .j    (j1),
        .k    (k1),
        .q    (q1),
        .qbar (qbar1)
    );

    jkff_structural #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
`ifdef JKFF_HOLD_EN
        .en   (en4),
`endif
        .j    (j4),
        .k    (k4),
        .q    (q4),
        .qbar (qbar4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural JK model: rules per bit, reset first, then enable.
    function automatic logic [3:0] jk_model(input logic [3:0] cur, input logic [3:0] jj,
                                            input logic [3:0] kk, input logic [3:0] ee,
                                            input logic rr, input logic [3:0] rv);
        logic [3:0] nxt;
        if (rr) return rv;
        for (int b = 0; b < 4; b++) begin
            if (!ee[b]) begin
                nxt[b] = cur[b];
            end else begin
                case ({jj[b], kk[b]})
                    2'b00:   nxt[b] = cur[b];
                    2'b01:   nxt[b] = 1'b0;
                    2'b10:   nxt[b] = 1'b1;
                    default: nxt[b] = !cur[b];
                endcase
            end
        end
        return nxt;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] mq1, mq4, en_r;
        logic       rr;
        logic [3:0] exp_q;

        rst = 1'b0; j1 = '0; k1 = '0; j4 = '0; k4 = '0;
`ifdef JKFF_HOLD_EN
        en1 = 1'b1; en4 = 4'hF;
`endif

        // Directed table for the single-bit instance.
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0});

        // Power-up values before any edge.
        #1;
        chk("powerup_q1",    4'(q1),    4'b0000);
        chk("powerup_qbar1", 4'(qbar1), 4'b0001);
        chk("powerup_q4",    q4,        4'b1010);
        chk("powerup_qbar4", qbar4,     4'b0101);

        // Reset beats toggle.
        rst = 1'b1; j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
        step();
        chk("rst_vs_toggle_q1",    4'(q1),    4'b0000);
        chk("rst_vs_toggle_qbar1", 4'(qbar1), 4'b0001);
        chk("rst_vs_toggle_q4",    q4,        4'b1010);

        rst = 1'b0; j4 = '0; k4 = '0;
        foreach (vecs[i]) begin
            j1 = vecs[i].j;
            k1 = vecs[i].k;
            step();
            chk($sformatf("table%0d_q", i),    4'(q1),    4'(vecs[i].exp_q));
            chk($sformatf("table%0d_qbar", i), 4'(qbar1), 4'(!vecs[i].exp_q));
        end

        // No combinational path from j/k to q.
        j1 = 1'b1; k1 = 1'b0;
        #5;
        chk("no_comb_path_q1", 4'(q1), 4'b0000);
        step();
        chk("set_after_edge_q1", 4'(q1), 4'b0001);

        // Four-bit instance: reset, then mixed hold/reset/set/toggle.
        rst = 1'b1; j1 = 1'b0; k1 = 1'b0;
        step();
        chk("w4_reset_q", q4, 4'b1010);
        rst = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
`ifdef JKFF_HOLD_EN
        en4 = 4'b0000;
        step();
        chk("w4_en0_hold_q", q4, 4'b1010);
        en4 = 4'hF;
`endif
        step();
        chk("w4_mixed_q",    q4,    4'b1011);
        chk("w4_mixed_qbar", qbar4, 4'b0100);

        // rst asserted mid-cycle acts only at the edge.
        j4 = '0; k4 = '0;
        #4;
        rst = 1'b1;
        #5;
        chk("rst_between_edges_q4", q4, 4'b1011);
        step();
        chk("rst_at_edge_q4", q4, 4'b1010);
        mq4 = 4'b1010;
        mq1 = 4'b0000;

        // Randomized stimulus against the model.
        for (int c = 0; c < 300; c++) begin
            rr   = ($urandom_range(0, 15) == 0);
            en_r = 4'hF;
            rst  = rr;
            j1   = 1'($urandom);
            k1   = 1'($urandom);
            j4   = 4'($urandom);
            k4   = 4'($urandom);
`ifdef JKFF_HOLD_EN
            en1  = 1'($urandom);
            en4  = 4'($urandom);
            en_r = en4;
            mq1  = jk_model(mq1, 4'(j1), 4'(k1), 4'(en1), rr, 4'b0000) & 4'b0001;
`else
            mq1  = jk_model(mq1, 4'(j1), 4'(k1), 4'b0001, rr, 4'b0000) & 4'b0001;
`endif
            mq4  = jk_model(mq4, j4, k4, en_r, rr, 4'b1010);
            step();
            exp_q = mq4;
            chk($sformatf("rand%0d_q4", c),    q4,        exp_q);
            chk($sformatf("rand%0d_qbar4", c), qbar4,     ~exp_q);
            chk($sformatf("rand%0d_q1", c),    4'(q1),    mq1);
            chk($sformatf("rand%0d_qbar1", c), 4'(qbar1), 4'(!mq1[0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
